// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM encoding and the
// register-file geometry defaults it shares with the core's integer register file.
package regfile_dump_reader_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_t;

  // First index visited by a walk; x0 is hard-wired zero and may be skipped.
  function automatic int first_index(input bit skip_x0);
    return skip_x0 ? 1 : 0;
  endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Index-tagged valid/ready beat stream carrying captured register values.
interface regfile_dump_reader_if
  import regfile_dump_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_idx;
  logic              m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_idx,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_idx,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks the register file's spare read port and streams each value as an indexed beat, with a running XOR.
// Two cycles per beat (READ, SEND); a presented beat is held until m_ready, and stop only acts at a handshake.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter bit SKIP_X0  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  output logic [ADDR_W-1:0]     rf_addr,
  input  logic [DATA_W-1:0]     rf_data,
  regfile_dump_reader_if.master m,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     xsum
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(first_index(SKIP_X0));
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  dump_state_t       state;
  logic [ADDR_W-1:0] idx;
  logic              abort_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] idx_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] xsum_q;

  wire handshake = valid_q && m.m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      abort_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      xsum_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx     <= FIRST_IDX;
            xsum_q  <= '0;
            abort_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= ST_READ;
          end
        end

        ST_READ: begin
          // rf_addr already equals idx, so rf_data is the value to capture.
          data_q  <= rf_data;
          idx_q   <= idx;
          last_q  <= (idx == LAST_IDX);
          valid_q <= 1'b1;
          abort_q <= abort_q | stop;
          state   <= ST_SEND;
        end

        ST_SEND: begin
          abort_q <= abort_q | stop;
          if (handshake) begin
            xsum_q  <= xsum_q ^ data_q;
            valid_q <= 1'b0;
            if (last_q) begin
              done_q <= 1'b1;
              state  <= ST_DONE;
            end else if (abort_q || stop) begin
              busy_q <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              idx   <= idx + ADDR_W'(1);
              state <= ST_READ;
            end
          end
        end

        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign rf_addr   = idx;
  assign m.m_valid = valid_q;
  assign m.m_data  = data_q;
  assign m.m_idx   = idx_q;
  assign m.m_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign xsum      = xsum_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench: full dumps (with and without x0), backpressure, abort, start-while-busy, reset mid-dump.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b, stop_a, stop_b;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [31:0] rf_data_a, rf_data_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [31:0] xsum_a, xsum_b;
  logic [31:0] regs [32];

  int n_assert = 0;
  int n_fail   = 0;
  bit sel_b    = 1'b0;

  always #5 clk = ~clk;

  regfile_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) ia ();
  regfile_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) ib ();

  regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a),
    .rf_addr(rf_addr_a), .rf_data(rf_data_a), .m(ia.master),
    .busy(busy_a), .done(done_a), .xsum(xsum_a)
  );

  regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b),
    .rf_addr(rf_addr_b), .rf_data(rf_data_b), .m(ib.master),
    .busy(busy_b), .done(done_b), .xsum(xsum_b)
  );

  assign rf_data_a = regs[rf_addr_a];
  assign rf_data_b = regs[rf_addr_b];

  // Observation mux so one task can check either instance.
  logic        s_valid, s_last, s_busy, s_done;
  logic [4:0]  s_idx;
  logic [31:0] s_data, s_xsum;
  assign s_valid = sel_b ? ib.m_valid : ia.m_valid;
  assign s_last  = sel_b ? ib.m_last  : ia.m_last;
  assign s_idx   = sel_b ? ib.m_idx   : ia.m_idx;
  assign s_data  = sel_b ? ib.m_data  : ia.m_data;
  assign s_busy  = sel_b ? busy_b     : busy_a;
  assign s_done  = sel_b ? done_b     : done_a;
  assign s_xsum  = sel_b ? xsum_b     : xsum_a;

  function automatic logic [31:0] exp_reg(input int i);
    return (i == 1) ? 32'd6 : (i == 2) ? 32'd7 : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full dump with m_ready high; returns in the DONE cycle. Optionally pokes start while busy.
  task automatic full_dump(input bit use_b, input bit inject);
    int first;
    int nb;
    first = use_b ? 1 : 0;
    nb    = 32 - first;
    sel_b = use_b;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    chk("fd_c1_busy", 32'(s_busy), 1);
    chk("fd_c1_valid", 32'(s_valid), 0);
    if (inject) start_a = 1'b1;
    for (int k = 0; k < nb; k++) begin
      tick();
      start_a = 1'b0;
      chk("fd_beat_valid", 32'(s_valid), 1);
      chk("fd_beat_idx", 32'(s_idx), 32'(first + k));
      chk("fd_beat_data", s_data, exp_reg(first + k));
      chk("fd_beat_last", 32'(s_last), (first + k == 31) ? 1 : 0);
      if (inject && k == 5) start_a = 1'b1;
      if (k < nb - 1) begin
        tick();
        start_a = 1'b0;
        chk("fd_gap_valid", 32'(s_valid), 0);
        chk("fd_gap_done", 32'(s_done), 0);
      end
    end
    tick();
    chk("fd_done", 32'(s_done), 1);
    chk("fd_done_busy", 32'(s_busy), 1);
    chk("fd_done_valid", 32'(s_valid), 0);
    chk("fd_xsum", s_xsum, 32'd1);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[1] = 32'd6;
    regs[2] = 32'd7;
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; stop_a = 1'b0; stop_b = 1'b0;
    ia.m_ready = 1'b1;
    ib.m_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(ia.m_valid), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_xsum", xsum_a, 0);
    chk("rst_rf_addr", 32'(rf_addr_a), 0);
    rst_n = 1'b1;
    tick();

    // Full dump, start poked while busy must be ignored.
    full_dump(1'b0, 1'b1);
    tick();
    chk("post_done_done", 32'(done_a), 0);
    chk("post_done_busy", 32'(busy_a), 0);
    chk("post_done_xsum_hold", xsum_a, 32'd1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("restart_busy", 32'(busy_a), 1);
    chk("restart_xsum_clr", xsum_a, 0);
    tick();
    chk("restart_idx0_valid", 32'(ia.m_valid), 1);
    chk("restart_idx0", 32'(ia.m_idx), 0);

    // Run on to idx 10, then reset while it is presented.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (ia.m_valid && ia.m_idx == 5'd10) found = 1'b1;
      else tick();
    end
    chk("reach_idx10", 32'(found), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(ia.m_valid), 0);
    chk("mid_rst_data", ia.m_data, 0);
    chk("mid_rst_idx", 32'(ia.m_idx), 0);
    chk("mid_rst_last", 32'(ia.m_last), 0);
    chk("mid_rst_busy", 32'(busy_a), 0);
    chk("mid_rst_done", 32'(done_a), 0);
    chk("mid_rst_xsum", xsum_a, 0);
    chk("mid_rst_rf_addr", 32'(rf_addr_a), 0);

    // Fresh dump after reset, with backpressure on idx 1 and abort on idx 3.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    chk("bp_idx0_valid", 32'(ia.m_valid), 1);
    chk("bp_idx0", 32'(ia.m_idx), 0);
    tick();
    tick();
    chk("bp_idx1", 32'(ia.m_idx), 1);
    chk("bp_idx1_data", ia.m_data, 32'd6);
    ia.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_valid", 32'(ia.m_valid), 1);
      chk("bp_hold_idx", 32'(ia.m_idx), 1);
      chk("bp_hold_data", ia.m_data, 32'd6);
    end
    tick();
    chk("bp_hold_valid_last", 32'(ia.m_valid), 1);
    ia.m_ready = 1'b1;
    tick();
    chk("bp_after_hs_valid", 32'(ia.m_valid), 0);
    tick();
    chk("bp_idx2_valid", 32'(ia.m_valid), 1);
    chk("bp_idx2", 32'(ia.m_idx), 2);
    chk("bp_idx2_data", ia.m_data, 32'd7);
    tick();
    tick();
    chk("ab_idx3", 32'(ia.m_idx), 3);
    ia.m_ready = 1'b0;
    stop_a = 1'b1;
    tick();
    stop_a = 1'b0;
    chk("ab_idx3_held", 32'(ia.m_valid), 1);
    chk("ab_busy_before", 32'(busy_a), 1);
    ia.m_ready = 1'b1;
    tick();
    chk("ab_busy_fall", 32'(busy_a), 0);
    chk("ab_valid_fall", 32'(ia.m_valid), 0);
    chk("ab_xsum", xsum_a, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ab_no_beat4", 32'(ia.m_valid), 0);
      chk("ab_no_done", 32'(done_a), 0);
    end

    // Skip-x0 instance: 31 beats, done in cycle 63.
    full_dump(1'b1, 1'b0);
    tick();
    chk("skip_idle_busy", 32'(busy_b), 0);
    chk("skip_idle_done", 32'(done_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug/readout engine on the spare read port of the 32×32 integer register file. On a start pulse it walks the register indices, captures each value from the file's combinational read data, and streams it out as index-tagged beats on a valid/ready interface. It also keeps a running XOR checksum. The block sits beside the core's register file and feeds a debug/trace sink; it never writes the file.

## Interface
Parameters:
- NUM_REGS, 32: number of registers walked; last index is NUM_REGS-1.
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.
- SKIP_X0, 0: when 1, the walk starts at index 1 (x0 is hard-wired zero).

Ports (one clock; reset is synchronous and active-low):
- clk, in, 1: sole clock, all state on posedge.
- rst_n, in, 1: synchronous active-low reset.
- start, in, 1: one-cycle request to begin a dump; ignored unless idle.
- stop, in, 1: abort request; sticky until honoured.
- rf_addr, out, ADDR_W: address to register file read port (a1/a2-style, combinational read).
- rf_data, in, DATA_W: read data returned by the register file in the same cycle.
- m_valid, out, 1: beat valid.
- m_ready, in, 1: sink ready.
- m_data, out, DATA_W: captured register value.
- m_idx, out, ADDR_W: index of m_data.
- m_last, out, 1: beat is the final index (NUM_REGS-1).
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse after a complete (non-aborted) dump.
- xsum, out, DATA_W: XOR of all accepted m_data in the current or most recent dump.

## Operation
- FSM states: IDLE, READ, SEND, DONE.
- IDLE: on start, set idx to 0, or 1 if SKIP_X0. Clear xsum and abort_q, then go to READ.
- READ: rf_addr = idx. Register m_data <= rf_data, m_idx <= idx, m_last <= (idx == NUM_REGS-1), m_valid <= 1. Go to SEND.
- SEND: hold m_data/m_idx/m_last/m_valid stable while m_ready is low. On a handshake (m_valid && m_ready):
  - xsum ^= m_data; m_valid <= 0.
  - If m_last, go to DONE.
  - Else if abort_q or stop, go to IDLE.
  - Else idx++ and go to READ.
- DONE: done = 1 for this cycle only, then go to IDLE.
- stop is latched into abort_q in READ or SEND. It takes effect only at the next handshake, so a presented beat is never retracted. stop in IDLE or DONE is ignored. An aborted dump produces no done pulse.
- start while busy is ignored (not queued).
- rf_addr is driven from idx at all times. Data is sampled only in READ, and concurrent register-file writes are not coherent beyond that sample point.
- idx never wraps; the walk terminates at NUM_REGS-1.

## Timing
- Reset (rst_n low at a posedge) values: state IDLE, idx 0, rf_addr 0, m_valid 0, m_data 0, m_idx 0, m_last 0, busy 0, done 0, xsum 0, abort_q 0. Reset overrides everything, including mid-dump.
- start sampled at cycle 0 → READ in cycle 1 → first m_valid in cycle 2.
- Throughput: at most one beat per 2 cycles (READ + SEND).
- With m_ready held high and SKIP_X0=0:
  - beats occur in cycles 2, 4, …, 64;
  - done pulses in cycle 65;
  - busy is high from cycle 1 through cycle 65.
- xsum is final in the cycle done is high and holds until the next accepted start.

## Structure
- Shared package: FSM state enum, NUM_REGS/ADDR_W/DATA_W defaults (shared with the register file).
- Single module, no sub-module. The valid/ready output register is simple enough to stay inline.

## Test plan
- Full dump, SKIP_X0=0, register file preloaded x1=6, x2=7, others 0, m_ready=1 → 32 beats idx 0..31, data 0,6,7,0…; m_last only on idx 31; done in cycle 65; xsum=1.
- Backpressure: m_ready low for 5 cycles while idx 1 is presented → m_valid stays 1, m_data=6 and m_idx=1 stable; idx 2 follows 2 cycles after the handshake.
- Abort: stop pulsed while idx 3 is waiting in SEND → beat 3 completes, no beat 4, busy falls the cycle after the handshake, done never asserts.
- start during busy is ignored. start in the cycle after DONE begins a fresh dump at idx 0 with xsum cleared.
- Reset mid-dump: rst_n low while idx 10 is presented → next cycle all outputs at reset values; a following start yields idx 0 first.
- SKIP_X0=1 → 31 beats, first m_idx=1, last m_idx=31 with m_last; done in cycle 63.
